// File: rtl/traffic_pkg.sv
// Shared types and constants for the junction lamp drivers.
// Lamp codes are one-hot per lane so the red/yellow/green exclusivity falls out of the encoding.
package traffic_pkg;

    localparam int NUM_LANES_DEF    = 4;
    localparam int LANE_W_DEF       = 2;
    localparam int YELLOW_TICKS_DEF = 3;
    localparam int ALLRED_TICKS_DEF = 1;

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_e;

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    // Only the active lane may show anything other than red.
    function automatic logic [2:0] lamp_code(state_e st, logic is_active);
        logic [2:0] code;
        code = LAMP_RED;
        if (is_active) begin
            case (st)
                S_GREEN:  code = LAMP_GREEN;
                S_YELLOW: code = LAMP_YELLOW;
                default:  code = LAMP_RED;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/phase_tick_timer.sv
// Tick-enabled up-counter with synchronous clear, saturation at limit-1 and a done strobe.
// done fires on the tick that would carry the count past limit-1.
module phase_tick_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         tick_en_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic         at_limit;

    assign at_limit = (count_q == (limit_i - W'(1)));
    assign done_o   = tick_en_i & at_limit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (tick_en_i && !at_limit) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/lane_signal_driver.sv
// Decodes the granted lane index into per-lane lamp drives, always inserting
// yellow and an all-red clearance between two greens.
module lane_signal_driver
    import traffic_pkg::*;
#(
    parameter int NUM_LANES    = NUM_LANES_DEF,
    parameter int LANE_W       = LANE_W_DEF,
    parameter int YELLOW_TICKS = YELLOW_TICKS_DEF,
    parameter int ALLRED_TICKS = ALLRED_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_en,
    input  logic [LANE_W-1:0]    lane_sel,
    input  logic                 emergency,
    output logic [NUM_LANES-1:0] green,
    output logic [NUM_LANES-1:0] yellow,
    output logic [NUM_LANES-1:0] red,
    output logic [LANE_W-1:0]    active_lane,
    output logic                 changing
);

    localparam int MAX_TICKS = (YELLOW_TICKS > ALLRED_TICKS) ? YELLOW_TICKS : ALLRED_TICKS;
    localparam int TIMER_W   = $clog2(MAX_TICKS + 1);

    state_e                state_q, state_d;
    logic [LANE_W-1:0]     active_q, active_d;
    logic [NUM_LANES-1:0]  green_q, yellow_q, red_q;
    logic [NUM_LANES-1:0]  green_d, yellow_d, red_d;
    logic                  changing_q;
    logic [2**LANE_W-1:0]  lane_valid;
    logic                  lane_ok;
    logic                  timer_clear;
    logic                  timer_done;
    logic [TIMER_W-1:0]    timer_limit;
    logic [2:0]            lamp;

    // Table of legal lane indices; avoids a compare that is constant when NUM_LANES == 2**LANE_W.
    for (genvar i = 0; i < 2**LANE_W; i++) begin : g_valid
        assign lane_valid[i] = (i < NUM_LANES);
    end
    assign lane_ok = lane_valid[lane_sel];

    assign timer_limit = (state_q == S_YELLOW) ? TIMER_W'(YELLOW_TICKS) : TIMER_W'(ALLRED_TICKS);
    // Held clear in GREEN and on every state change, so each phase starts counting from zero.
    assign timer_clear = (state_q == S_GREEN) || (state_d != state_q);

    phase_tick_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timer_clear),
        .tick_en_i (tick_en),
        .limit_i   (timer_limit),
        .done_o    (timer_done)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        case (state_q)
            S_GREEN: begin
                if (lane_sel != active_q || emergency || !lane_ok) begin
                    state_d = S_YELLOW;
                end
            end
            S_YELLOW: begin
                if (timer_done) begin
                    state_d = S_ALLRED;
                end
            end
            default: begin
                if (timer_done && !emergency && lane_ok) begin
                    state_d  = S_GREEN;
                    active_d = lane_sel;
                end
            end
        endcase
    end

    // Lamps decoded from the next state so they switch on the same edge as the state.
    always_comb begin
        green_d  = '0;
        yellow_d = '0;
        red_d    = '0;
        lamp     = LAMP_RED;
        for (int i = 0; i < NUM_LANES; i++) begin
            lamp        = lamp_code(state_d, active_d == LANE_W'(i));
            red_d[i]    = lamp[0];
            yellow_d[i] = lamp[1];
            green_d[i]  = lamp[2];
        end
    end

    // NOTE: async reset forces all lamps red at once, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ALLRED;
            active_q   <= '0;
            green_q    <= '0;
            yellow_q   <= '0;
            red_q      <= '1;
            changing_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            active_q   <= active_d;
            green_q    <= green_d;
            yellow_q   <= yellow_d;
            red_q      <= red_d;
            changing_q <= (state_d != S_GREEN);
        end
    end

    assign green       = green_q;
    assign yellow      = yellow_q;
    assign red         = red_q;
    assign active_lane = active_q;
    assign changing    = changing_q;

endmodule

// File: tb/tb_lane_signal_driver.sv
// Directed scenarios plus a random soak for the lane lamp driver (4 lanes, 3 yellow, 1 all-red).
// Observed vector layout: {green, yellow, red, active_lane, changing}.
module tb_lane_signal_driver;

    logic       clk;
    logic       rst_n;
    logic       tick_en;
    logic [1:0] lane_sel;
    logic       emergency;
    logic [3:0] green, yellow, red;
    logic [1:0] active_lane;
    logic       changing;

    int n_checks = 0;
    int n_pass   = 0;

    lane_signal_driver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick_en     (tick_en),
        .lane_sel    (lane_sel),
        .emergency   (emergency),
        .green       (green),
        .yellow      (yellow),
        .red         (red),
        .active_lane (active_lane),
        .changing    (changing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] obs();
        return {green, yellow, red, active_lane, changing};
    endfunction

    // One clock with the given tick_en; returns 1 time unit after the edge.
    task automatic cycle(input logic t);
        tick_en = t;
        @(posedge clk);
        #1;
        tick_en = 1'b0;
    endtask

    // Full nominal change to lane l: 1 exit clk, 3 yellow ticks, 1 all-red tick.
    task automatic go_to_lane(input logic [1:0] l);
        lane_sel = l;
        cycle(1'b0);
        repeat (3) cycle(1'b1);
        cycle(1'b1);
    endtask

    task automatic test_reset();
        logic [14:0] e;
        rst_n = 1'b0; tick_en = 1'b0; lane_sel = 2'd0; emergency = 1'b0;
        #12;
        e = {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL reset_values got %b exp %b", obs(), e); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        cycle(1'b0);
        n_checks++;
        if (obs() !== e) $display("FAIL allred_no_tick got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL first_green got %b exp %b", obs(), e); else n_pass++;
    endtask

    task automatic test_lane_change();
        logic [14:0] e;
        cycle(1'b1);
        e = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL tick_in_green got %b exp %b", obs(), e); else n_pass++;
        lane_sel = 2'd1;
        cycle(1'b0);
        e = {4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL yellow_entry got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1); cycle(1'b0); cycle(1'b1);
        n_checks++;
        if (obs() !== e) $display("FAIL yellow_hold got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL allred_after_yellow got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL green_lane1 got %b exp %b", obs(), e); else n_pass++;
    endtask

    task automatic test_emergency();
        logic [14:0] e;
        go_to_lane(2'd2);
        e = {4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL green_lane2 got %b exp %b", obs(), e); else n_pass++;
        emergency = 1'b1;
        cycle(1'b0);
        e = {4'b0000, 4'b0100, 4'b1011, 2'd2, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL emerg_yellow got %b exp %b", obs(), e); else n_pass++;
        repeat (3) cycle(1'b1);
        lane_sel = 2'd3;
        repeat (10) cycle(1'b1);
        e = {4'b0000, 4'b0000, 4'b1111, 2'd2, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL emerg_allred_hold got %b exp %b", obs(), e); else n_pass++;
        emergency = 1'b0;
        cycle(1'b0);
        n_checks++;
        if (obs() !== e) $display("FAIL emerg_drop_no_tick got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b1000, 4'b0000, 4'b0111, 2'd3, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL emerg_release_green got %b exp %b", obs(), e); else n_pass++;
    endtask

    task automatic test_bounce();
        logic [14:0] e;
        go_to_lane(2'd0);
        lane_sel = 2'd3;
        cycle(1'b0);
        cycle(1'b1);
        lane_sel = 2'd0;
        cycle(1'b1);
        e = {4'b0000, 4'b0001, 4'b1110, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL bounce_yellow_continues got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL bounce_allred got %b exp %b", obs(), e); else n_pass++;
        cycle(1'b1);
        e = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL bounce_regrant_same got %b exp %b", obs(), e); else n_pass++;
    endtask

    task automatic test_async_reset();
        logic [14:0] e;
        lane_sel = 2'd1;
        cycle(1'b0);
        cycle(1'b1);
        #2 rst_n = 1'b0;
        #1;
        e = {4'b0000, 4'b0000, 4'b1111, 2'd0, 1'b1};
        n_checks++;
        if (obs() !== e) $display("FAIL async_reset_immediate got %b exp %b", obs(), e); else n_pass++;
        #2 rst_n = 1'b1;
        lane_sel = 2'd0;
        cycle(1'b1);
        e = {4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b0};
        n_checks++;
        if (obs() !== e) $display("FAIL restart_green got %b exp %b", obs(), e); else n_pass++;
    endtask

    task automatic test_random();
        logic       prev_green;
        logic [1:0] prev_lane;
        logic       seen_y;
        logic       seq_ok;
        logic       bad;
        logic [1:0] gl;
        int         nonred;
        rst_n = 1'b0; emergency = 1'b0;
        #3 rst_n = 1'b1;
        prev_green = 1'b0; prev_lane = 2'd0; seen_y = 1'b0; seq_ok = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            lane_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) emergency = ~emergency;
            cycle(1'($urandom_range(0, 1)));
            bad = 1'b0; nonred = 0; gl = 2'd0;
            for (int i = 0; i < 4; i++) begin
                if (!$onehot({red[i], yellow[i], green[i]})) bad = 1'b1;
                if (!red[i]) nonred++;
                if (green[i]) gl = 2'(i);
            end
            n_checks++;
            if (bad) $display("FAIL rand_lane_onehot cyc %0d got r=%b y=%b g=%b", n, red, yellow, green);
            else n_pass++;
            n_checks++;
            if (nonred > 1) $display("FAIL rand_single_nonred cyc %0d got %0d lanes exp <=1", n, nonred);
            else n_pass++;
            n_checks++;
            if (|green && ((prev_green && gl != prev_lane) || (!prev_green && !seq_ok)))
                $display("FAIL rand_green_sequence cyc %0d got lane %0d after lane %0d seq_ok=%b",
                         n, gl, prev_lane, seq_ok);
            else n_pass++;
            if (|green) begin
                seq_ok = 1'b0; seen_y = 1'b0; prev_lane = gl;
            end else if (|yellow) begin
                seen_y = 1'b1;
            end else if (seen_y) begin
                seq_ok = 1'b1;
            end
            prev_green = |green;
        end
        emergency = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lane_change();
        test_emergency();
        test_bounce();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
